// File: rtl/lpc_host.sv
// LPC host initiator for TPM cycles: turns single-byte read/write requests into
// LFRAME#/LAD frames, samples SYNC and read data, and returns a one-shot response.
module lpc_host #(
  parameter int unsigned SYNC_TIMEOUT = 256,
  parameter int unsigned ABORT_CLOCKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        resp_valid_o,
  output logic [7:0]  resp_data_o,
  output logic [1:0]  resp_status_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe,
  input  logic [3:0]  lad_i
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_TARH1,
    ST_TARH2,
    ST_SYNC,
    ST_RDATA,
    ST_TARP1,
    ST_TARP2,
    ST_ABORT,
    ST_ABORT_END,
    ST_DONE
  } state_e;

  localparam logic [3:0] LAD_START_TPM = 4'b0101;
  localparam logic [3:0] LAD_CYC_WRITE = 4'b0010;
  localparam logic [3:0] LAD_CYC_READ  = 4'b0000;
  localparam logic [3:0] LAD_IDLE      = 4'hF;
  localparam logic [3:0] SYNC_READY    = 4'b0000;
  localparam logic [3:0] SYNC_ERROR    = 4'b1010;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ERR     = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  localparam logic [9:0] SYNC_LAST  = 10'(SYNC_TIMEOUT - 1);
  localparam logic [9:0] ABORT_LAST = 10'(ABORT_CLOCKS - 1);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  status_q, status_d;

  logic        lframe_q, lframe_d;
  logic [3:0]  lad_q, lad_d;
  logic        lad_oe_q, lad_oe_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic [1:0]  resp_status_q, resp_status_d;

  // cnt_q is shared: ADDR/WDATA/RDATA nibble index, SYNC wait count, ABORT length.
  always_comb begin : next_state
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_d        = data_q;
    status_d      = status_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          wr_d     = req_wr_i;
          addr_d   = req_addr_i;
          wdata_d  = req_data_i;
          data_d   = 8'h00;
          status_d = STATUS_OK;
          state_d  = ST_START;
        end
      end
      ST_START:   state_d = ST_CYCTYPE;
      ST_CYCTYPE: begin
        state_d = ST_ADDR;
        cnt_d   = '0;
      end
      ST_ADDR: begin
        if (cnt_q == 10'd3) begin
          state_d = wr_q ? ST_WDATA : ST_TARH1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_WDATA: begin
        if (cnt_q == 10'd1) state_d = ST_TARH1;
        else                cnt_d   = cnt_q + 10'd1;
      end
      ST_TARH1: state_d = ST_TARH2;
      ST_TARH2: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
      ST_SYNC: begin
        // A ready/error code on the last allowed clock still wins over the timeout.
        if (lad_i == SYNC_READY || lad_i == SYNC_ERROR) begin
          if (lad_i == SYNC_ERROR) status_d = STATUS_ERR;
          state_d = wr_q ? ST_TARP1 : ST_RDATA;
          cnt_d   = '0;
        end else if (cnt_q == SYNC_LAST) begin
          state_d  = ST_ABORT;
          cnt_d    = '0;
          status_d = STATUS_TIMEOUT;
          data_d   = 8'hFF;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_RDATA: begin
        if (cnt_q == 10'd0) begin
          data_d[3:0] = lad_i;
          cnt_d       = cnt_q + 10'd1;
        end else begin
          data_d[7:4] = lad_i;
          state_d     = ST_TARP1;
        end
      end
      ST_TARP1: state_d = ST_TARP2;
      ST_TARP2: state_d = ST_DONE;
      ST_ABORT: begin
        if (cnt_q == ABORT_LAST) state_d = ST_ABORT_END;
        else                     cnt_d   = cnt_q + 10'd1;
      end
      ST_ABORT_END: state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = data_d;
      resp_status_d = status_d;
    end
  end

  // Bus outputs are decoded from the next state so they are registered yet aligned to it.
  always_comb begin : bus_decode
    lframe_d    = 1'b1;
    lad_oe_d    = 1'b0;
    lad_d       = LAD_IDLE;
    req_ready_d = (state_d == ST_IDLE);

    case (state_d)
      ST_START: begin
        lframe_d = 1'b0;
        lad_oe_d = 1'b1;
        lad_d    = LAD_START_TPM;
      end
      ST_CYCTYPE: begin
        lad_oe_d = 1'b1;
        lad_d    = wr_d ? LAD_CYC_WRITE : LAD_CYC_READ;
      end
      ST_ADDR: begin
        lad_oe_d = 1'b1;
        case (cnt_d[1:0])
          2'd0:    lad_d = addr_d[15:12];
          2'd1:    lad_d = addr_d[11:8];
          2'd2:    lad_d = addr_d[7:4];
          default: lad_d = addr_d[3:0];
        endcase
      end
      ST_WDATA: begin
        lad_oe_d = 1'b1;
        lad_d    = cnt_d[0] ? wdata_d[7:4] : wdata_d[3:0];
      end
      ST_TARH1: lad_oe_d = 1'b1;
      ST_ABORT: begin
        lframe_d = 1'b0;
        lad_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_q        <= '0;
      status_q      <= STATUS_OK;
      lframe_q      <= 1'b1;
      lad_q         <= LAD_IDLE;
      lad_oe_q      <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 8'h00;
      resp_status_q <= STATUS_OK;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_q        <= data_d;
      status_q      <= status_d;
      lframe_q      <= lframe_d;
      lad_q         <= lad_d;
      lad_oe_q      <= lad_oe_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign lframe_o      = lframe_q;
  assign lad_o         = lad_q;
  assign lad_oe        = lad_oe_q;
  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = resp_data_q;
  assign resp_status_o = resp_status_q;

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: per-clock bus table for a write, a transaction
// table with a small peripheral model, and hand sequences for abort/reset/back-to-back.
module tb_lpc_host;

  localparam int unsigned SYNC_TO = 8;
  localparam int unsigned ABORT_N = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_data_i;
  logic        resp_valid_o;
  logic [7:0]  resp_data_o;
  logic [1:0]  resp_status_o;
  logic        lframe_o;
  logic [3:0]  lad_o;
  logic        lad_oe;
  logic [3:0]  lad_i;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] last_data;

  always #5 clk = ~clk;

  lpc_host #(.SYNC_TIMEOUT(SYNC_TO), .ABORT_CLOCKS(ABORT_N)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wr_i     (req_wr_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_status_o(resp_status_o),
    .lframe_o     (lframe_o),
    .lad_o        (lad_o),
    .lad_oe       (lad_oe),
    .lad_i        (lad_i)
  );

  typedef struct {
    logic [3:0] lad_in;
    logic       exp_lframe;
    logic       exp_oe;
    logic [3:0] exp_lad;
    logic       exp_ready;
    logic       exp_rvalid;
  } bus_vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          waits;
    logic [3:0]  wait_code;
    logic [3:0]  sync_code;
    logic [7:0]  rdata;
    logic [7:0]  exp_data;
    logic [1:0]  exp_status;
    int          exp_lat;
  } txn_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Peripheral model: what it drives on LAD in clock A+k of a transaction.
  function automatic logic [3:0] periph_nib(input txn_t t, input int k);
    int ss;
    ss = t.wr ? 11 : 9;
    if (k >= ss && k < ss + t.waits) return t.wait_code;
    if (k == ss + t.waits) return t.sync_code;
    if (!t.wr && k == ss + t.waits + 1) return t.rdata[3:0];
    if (!t.wr && k == ss + t.waits + 2) return t.rdata[7:4];
    return 4'hF;
  endfunction

  task automatic run_txn(input txn_t t, input string name);
    int got_k;
    int ready_bad;
    int oe_bad;
    int ss;
    got_k     = -1;
    ready_bad = 0;
    oe_bad    = 0;
    ss        = t.wr ? 11 : 9;
    @(negedge clk);
    check({name, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    check({name, "_hold"}, {24'd0, resp_data_o}, {24'd0, last_data});
    req_valid_i = 1'b1;
    req_wr_i    = t.wr;
    req_addr_i  = t.addr;
    req_data_i  = t.wdata;
    for (int k = 1; k <= t.exp_lat + 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid_i = 1'b0;
      lad_i = periph_nib(t, k);
      if (req_ready_o !== 1'b0) ready_bad++;
      if (t.exp_status != 2'b10 && k >= ss - 1 && lad_oe !== 1'b0) oe_bad++;
      if (resp_valid_o === 1'b1) begin
        got_k = k;
        break;
      end
    end
    lad_i = 4'hF;
    check({name, "_latency"}, got_k, t.exp_lat);
    check({name, "_data"}, {24'd0, resp_data_o}, {24'd0, t.exp_data});
    check({name, "_status"}, {30'd0, resp_status_o}, {30'd0, t.exp_status});
    check({name, "_ready_low"}, ready_bad, 0);
    check({name, "_oe_released"}, oe_bad, 0);
    last_data = t.exp_data;
  endtask

  bus_vec_t bv[14];
  txn_t     tt[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t wtx;
    txn_t rtx;
    int bad;
    int d_k;

    // START, CYCTYPE, ADDR 0F80, WDATA 5A (LSN first), TARH1/2, SYNC, TARP1/2, DONE.
    bv[0]  = '{4'hF, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0};
    bv[1]  = '{4'hF, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
    bv[2]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
    bv[3]  = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0};
    bv[4]  = '{4'hF, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0};
    bv[5]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0};
    bv[6]  = '{4'hF, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0};
    bv[7]  = '{4'hF, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0};
    bv[8]  = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0};
    bv[9]  = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    bv[10] = '{4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    bv[11] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    bv[12] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
    bv[13] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};

    tt[0] = '{1'b0, 16'h0F00, 8'h00, 3,   4'b0101, 4'b0000, 8'hD1, 8'hD1, 2'b00, 17};
    tt[1] = '{1'b0, 16'h0C00, 8'h00, 0,   4'b0101, 4'b1010, 8'h00, 8'h00, 2'b01, 14};
    tt[2] = '{1'b1, 16'h1234, 8'hC3, 2,   4'b0110, 4'b1010, 8'h00, 8'h00, 2'b01, 16};
    tt[3] = '{1'b0, 16'h00FF, 8'h00, 7,   4'b0101, 4'b0000, 8'h3C, 8'h3C, 2'b00, 21};
    tt[4] = '{1'b1, 16'hABCD, 8'h81, 100, 4'b0011, 4'b0000, 8'h00, 8'hFF, 2'b10, 24};
    tt[5] = '{1'b0, 16'h8001, 8'h00, 0,   4'b0101, 4'b0000, 8'hA5, 8'hA5, 2'b00, 14};
    tt[6] = '{1'b1, 16'hFFFF, 8'h00, 0,   4'b0101, 4'b0000, 8'h00, 8'h00, 2'b00, 14};

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_wr_i    = 1'b0;
    req_addr_i  = 16'h0000;
    req_data_i  = 8'h00;
    lad_i       = 4'hF;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("reset_bus", {25'd0, lframe_o, lad_oe, lad_o, req_ready_o, resp_valid_o},
          {25'd0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0});
    check("reset_resp", {22'd0, resp_data_o, resp_status_o}, 32'd0);

    // Write 0x5A to 0x0F80 with immediate ready, checked clock by clock.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wr_i    = 1'b1;
    req_addr_i  = 16'h0F80;
    req_data_i  = 8'h5A;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) req_valid_i = 1'b0;
      lad_i = bv[i].lad_in;
      check($sformatf("wr_bus_A+%0d", i + 1),
            {25'd0, lframe_o, lad_oe, bv[i].exp_oe ? lad_o : 4'h0, req_ready_o, resp_valid_o},
            {25'd0, bv[i].exp_lframe, bv[i].exp_oe, bv[i].exp_oe ? bv[i].exp_lad : 4'h0,
             bv[i].exp_ready, bv[i].exp_rvalid});
    end
    lad_i = 4'hF;
    check("wr_resp", {22'd0, resp_data_o, resp_status_o}, {22'd0, 8'h00, 2'b00});
    last_data = 8'h00;

    for (int i = 0; i < 7; i++) run_txn(tt[i], $sformatf("txn%0d", i));

    // Timeout shape on a read: SYNC A+9..A+16, ABORT A+17..A+20, ABORT_END A+21, DONE A+22.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wr_i    = 1'b0;
    req_addr_i  = 16'h0000;
    bad         = 0;
    d_k         = -1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) req_valid_i = 1'b0;
      if (lframe_o !== ((k == 1 || (k >= 17 && k <= 20)) ? 1'b0 : 1'b1)) bad++;
      if (lad_oe !== ((k <= 7 || (k >= 17 && k <= 20)) ? 1'b1 : 1'b0)) bad++;
      if (k >= 17 && k <= 20 && lad_o !== 4'hF) bad++;
      if (resp_valid_o === 1'b1 && d_k < 0) d_k = k;
    end
    check("abort_shape", bad, 0);
    check("abort_done_clock", d_k, 22);
    check("abort_resp", {22'd0, resp_data_o, resp_status_o}, {22'd0, 8'hFF, 2'b10});
    last_data = 8'hFF;

    // Reset during the third ADDR clock (A+5).
    @(negedge clk);
    req_valid_i = 1'b1;
    req_wr_i    = 1'b1;
    req_addr_i  = 16'h0F80;
    req_data_i  = 8'h5A;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid_i = 1'b0;
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midreset_bus", {29'd0, lframe_o, lad_oe, req_ready_o}, {29'd0, 1'b1, 1'b0, 1'b1});
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid_o !== 1'b0) bad++;
      @(negedge clk);
    end
    check("midreset_no_resp", bad, 0);

    // Back-to-back: request held valid; write then read.
    wtx = '{1'b1, 16'h0F80, 8'h5A, 0, 4'b0101, 4'b0000, 8'h00, 8'h00, 2'b00, 14};
    rtx = '{1'b0, 16'h0F00, 8'h00, 0, 4'b0101, 4'b0000, 8'h96, 8'h96, 2'b00, 14};
    check("b2b_ready_first", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_wr_i    = 1'b1;
    req_addr_i  = wtx.addr;
    req_data_i  = wtx.wdata;
    bad         = 0;
    d_k         = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      lad_i = periph_nib(wtx, k);
      if (resp_valid_o === 1'b1) begin
        d_k = k;
        break;
      end
      if (req_ready_o !== 1'b0) bad++;
    end
    check("b2b_ready_low", bad, 0);
    check("b2b_first_done", d_k, 14);
    req_wr_i   = 1'b0;
    req_addr_i = rtx.addr;
    @(negedge clk);
    lad_i = 4'hF;
    check("b2b_accept", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    check("b2b_start", {27'd0, lframe_o, lad_o}, {27'd0, 1'b0, 4'h5});
    req_valid_i = 1'b0;
    lad_i       = periph_nib(rtx, 1);
    d_k         = -1;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      lad_i = periph_nib(rtx, k);
      if (resp_valid_o === 1'b1) begin
        d_k = k;
        break;
      end
    end
    lad_i = 4'hF;
    check("b2b_second_done", d_k, 14);
    check("b2b_second_resp", {22'd0, resp_data_o, resp_status_o}, {22'd0, 8'h96, 2'b00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
